// File: rtl/clock_gen_pkg.sv
// Shared definitions for the programmable clock divider: minimum ratio, ratio clamp, ratio type.
package clock_gen_pkg;

  localparam int unsigned DIV_MIN       = 2;
  localparam int          DIV_W_DEFAULT = 8;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  // Ratios of 0 and 1 cannot form a period with both a high and a low phase.
  function automatic int unsigned clamp_div(input int unsigned n);
    return (n < DIV_MIN) ? DIV_MIN : n;
  endfunction

endpackage

// File: rtl/clock_gen_cnt.sv
// Period counter for clock_gen: wrap detection and period-boundary ratio swap.
module clock_gen_cnt
  import clock_gen_pkg::*;
#(
  parameter int          DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  output logic [DIV_W-1:0] cnt_n,
  output logic             wrap,
  output logic [DIV_W-1:0] div_cur
);

  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(clamp_div(DIV_DEFAULT));

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] div_in;
  logic [DIV_W-1:0] div_park;
  logic             pend_vld;

  assign div_in   = DIV_W'(clamp_div(32'(div)));
  assign div_park = pend_vld ? div_pend : div_cur;
  assign cnt_n    = (cnt == div_cur - 1'b1) ? '0 : cnt + 1'b1;
  assign wrap     = (cnt_n == '0);

  // A strobe in the same cycle as a wrap is stored after the swap, so it waits for the next wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= DIV_RST - 1'b1;
      div_cur  <= DIV_RST;
      div_pend <= DIV_RST;
      pend_vld <= 1'b0;
    end else begin
      if (!en) begin
        div_cur  <= div_park;
        cnt      <= div_park - 1'b1;
        pend_vld <= 1'b0;
      end else begin
        cnt <= cnt_n;
        if (wrap && pend_vld) begin
          div_cur  <= div_pend;
          pend_vld <= 1'b0;
        end
      end
      if (div_load) begin
        div_pend <= div_in;
        pend_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_gen.sv
// Programmable integer clock divider with registered clk_out and tick outputs.
// Define CLOCK_GEN_ODD_DUTY50_EN to stretch odd-ratio high phases by half a clk for 50% duty.
module clock_gen
  import clock_gen_pkg::*;
#(
  parameter int          DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur
);

  logic [DIV_W-1:0] cnt_n;
  logic [DIV_W-1:0] h;
  logic             wrap;
  logic             clk_q;

  clock_gen_cnt #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (DIV_DEFAULT)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div      (div),
    .div_load (div_load),
    .cnt_n    (cnt_n),
    .wrap     (wrap),
    .div_cur  (div_cur)
  );

  assign h = div_cur >> 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_q <= 1'b0;
      tick  <= 1'b0;
    end else if (!en) begin
      clk_q <= 1'b0;
      tick  <= 1'b0;
    end else begin
      clk_q <= (cnt_n < h);
      tick  <= wrap;
    end
  end

`ifdef CLOCK_GEN_ODD_DUTY50_EN
  logic neg_q;

  // Half-cycle delayed copy; only odd ratios OR it in, even ratios already have 50% duty.
  always_ff @(negedge clk or posedge rst) begin
    if (rst)      neg_q <= 1'b0;
    else if (!en) neg_q <= 1'b0;
    else          neg_q <= clk_q;
  end

  assign clk_out = clk_q | (neg_q & div_cur[0]);
`else
  assign clk_out = clk_q;
`endif

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: directed period/duty checks plus randomized run vs a period model.
module tb_clock_gen;
  import clock_gen_pkg::*;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [DIV_W-1:0] div_cur;

  int checks = 0;
  int errors = 0;

  // Reference model: ratio in effect, pending ratio, and cycles elapsed since the last rising edge.
  int m_n, m_pend, m_pos;
  bit m_pvld, m_q, m_q_prev, m_t;

  clock_gen #(
    .DIV_W       (DIV_W),
    .DIV_DEFAULT (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .div      (div),
    .div_load (div_load),
    .clk_out  (clk_out),
    .tick     (tick),
    .div_cur  (div_cur)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampModel(input int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic resetModel();
    m_n = 2; m_pend = 2; m_pvld = 0; m_pos = 1;
    m_q = 0; m_q_prev = 0; m_t = 0;
  endtask

  task automatic modelStep(input bit e, input int d, input bit ld);
    m_q_prev = m_q;
    if (!e) begin
      if (m_pvld) begin m_n = m_pend; m_pvld = 0; end
      m_pos = m_n - 1;
      m_q = 0;
      m_t = 0;
    end else begin
      m_pos++;
      if (m_pos >= m_n) begin
        m_pos = 0;
        if (m_pvld) begin m_n = m_pend; m_pvld = 0; end
      end
      m_q = (m_pos < m_n / 2);
      m_t = (m_pos == 0);
    end
    if (ld) begin m_pend = clampModel(d); m_pvld = 1; end
  endtask

  task automatic applyStimulus(input bit e, input int d, input bit ld);
    int exp_out;
    en = e; div = d[DIV_W-1:0]; div_load = ld;
    @(posedge clk);
    modelStep(e, d, ld);
`ifdef CLOCK_GEN_ODD_DUTY50_EN
    exp_out = int'(m_q | (e & m_q_prev & (m_n % 2 == 1)));
`else
    exp_out = int'(m_q);
`endif
    #1;
    checkOutput("clk_out", clk_out, exp_out);
    checkOutput("tick", tick, m_t);
    checkOutput("div_cur", div_cur, m_n);
  endtask

  // Runs to the next tick, then measures one full period and its sampled high count.
  task automatic measurePeriod(output int wait_n, output int period, output int high);
    wait_n = 0; period = 0; high = 0;
    do begin
      applyStimulus(1, 0, 0);
      wait_n++;
    end while (!tick && wait_n < 64);
    if (!tick) begin
      checkOutput("tick_timeout", 0, 1);
      return;
    end
    high = int'(clk_out);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1, 0, 0);
      period++;
      if (tick) return;
      high += int'(clk_out);
    end
    checkOutput("period_timeout", 0, 1);
  endtask

  initial begin
    int w, p, hc, cyc;
    rst = 1; en = 1; div = '0; div_load = 0;
    resetModel();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_clk_out", clk_out, 0);
    checkOutput("rst_tick", tick, 0);
    checkOutput("rst_div_cur", div_cur, 2);
    rst = 0;

    applyStimulus(1, 0, 0);
    checkOutput("first_rise", clk_out, 1);
    checkOutput("first_tick", tick, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);

    applyStimulus(1, 4, 1);
    measurePeriod(w, p, hc);
    checkOutput("div4_period", p, 4);
    checkOutput("div4_high", hc, 2);
    checkOutput("div4_cur", div_cur, 4);

    applyStimulus(1, 5, 1);
    measurePeriod(w, p, hc);
    checkOutput("div5_period", p, 5);
`ifdef CLOCK_GEN_ODD_DUTY50_EN
    checkOutput("div5_high", hc, 3);
`else
    checkOutput("div5_high", hc, 2);
`endif

    applyStimulus(1, 4, 1);
    measurePeriod(w, p, hc);
    checkOutput("reload_base_period", p, 4);
    applyStimulus(1, 6, 1);
    measurePeriod(w, p, hc);
    checkOutput("reload_old_finish", w, 3);
    checkOutput("reload_period", p, 6);
    checkOutput("reload_high", hc, 3);
    checkOutput("reload_cur", div_cur, 6);

    applyStimulus(0, 0, 0);
    checkOutput("en_drop_clk_out", clk_out, 0);
    applyStimulus(1, 0, 0);
    checkOutput("en_rise_clk_out", clk_out, 1);
    checkOutput("en_rise_tick", tick, 1);

    applyStimulus(1, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("clamp0_cur", div_cur, 2);
    applyStimulus(0, 7, 1);
    applyStimulus(0, 1, 1);
    checkOutput("park_apply_cur", div_cur, 7);
    applyStimulus(0, 0, 0);
    checkOutput("clamp1_cur", div_cur, 2);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 9), $urandom_range(0, 7) == 0);

    applyStimulus(1, 6, 1);
    cyc = 0;
    while (!(m_n == 6 && m_pos == 1) && cyc < 40) begin
      applyStimulus(1, 0, 0);
      cyc++;
    end
    checkOutput("midrst_reach_high", int'(clk_out), 1);
    #1;
    rst = 1;
    #1;
    checkOutput("midrst_clk_out", clk_out, 0);
    checkOutput("midrst_tick", tick, 0);
    checkOutput("midrst_div_cur", div_cur, 2);
    resetModel();
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
